// File: rtl/ram_arbiter_nch.sv
// N-channel request arbiter: funnels client read/write requests onto one DDRAM command port.
// Fixed-priority or round-robin grant, registered outputs, read watchdog.
module ram_arbiter_nch #(
    parameter int NCH     = 4,
    parameter int ADDR_W  = 29,
    parameter int DATA_W  = 64,
    parameter int MODE    = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NCH-1:0]             ch_req,
    input  logic [NCH-1:0]             ch_write,
    input  logic [NCH*ADDR_W-1:0]      ch_addr,
    input  logic [NCH*DATA_W-1:0]      ch_wdata,
    input  logic [NCH*(DATA_W/8)-1:0]  ch_be,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [NCH-1:0]             ch_ready,
    output logic [NCH-1:0]             ch_done,
    output logic                       err_timeout,
    input  logic                       mem_busy,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd,
    output logic                       mem_we,
    output logic [DATA_W-1:0]          mem_din,
    output logic [DATA_W/8-1:0]        mem_be,
    output logic [7:0]                 mem_burstcnt,
    input  logic [DATA_W-1:0]          mem_dout,
    input  logic                       mem_dout_ready
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(NCH);
    localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, ACK, GAP} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   ch_rdata_q, ch_rdata_d;
    logic [NCH-1:0]      ch_ready_q, ch_ready_d;
    logic [NCH-1:0]      ch_done_q, ch_done_d;
    logic                err_q, err_d;

    logic [NCH-1:0]      active;
    logic                any_active;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    idx;

    // Descending scan so the last hit is the highest-priority candidate.
    always_comb begin
        active     = ch_req | ch_write;
        any_active = |active;
        pick       = '0;
        idx        = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = PTR_W'((MODE == 0) ? (k - 1) : ((int'(rr_ptr_q) + k) % NCH));
            if (active[idx]) pick = idx;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        wd_d       = wd_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_be_d   = mem_be_q;
        mem_rd_d   = mem_rd_q;
        mem_we_d   = mem_we_q;
        ch_rdata_d = ch_rdata_q;
        ch_ready_d = '0;
        ch_done_d  = '0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_active) begin
                    grant_d    = pick;
                    if (MODE != 0) rr_ptr_d = pick;
                    mem_addr_d = ch_addr[int'(pick)*ADDR_W +: ADDR_W];
                    mem_din_d  = ch_wdata[int'(pick)*DATA_W +: DATA_W];
                    mem_be_d   = ch_write[pick] ? ch_be[int'(pick)*BE_W +: BE_W] : '1;
                    mem_we_d   = ch_write[pick];
                    mem_rd_d   = !ch_write[pick];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!mem_busy) begin
                    mem_we_d = 1'b0;
                    mem_rd_d = 1'b0;
                    if (mem_we_q) begin
                        ch_done_d[grant_q] = 1'b1;
                        state_d            = ACK;
                    end else begin
                        wd_d    = '0;
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                // Returned data beats a watchdog expiry on the same edge.
                if (mem_dout_ready) begin
                    ch_rdata_d          = mem_dout;
                    ch_ready_d[grant_q] = 1'b1;
                    state_d             = ACK;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    ch_rdata_d          = '1;
                    ch_ready_d[grant_q] = 1'b1;
                    err_d               = 1'b1;
                    state_d             = ACK;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ACK:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PTR_W'(NCH - 1);
            grant_q    <= '0;
            wd_q       <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_be_q   <= '0;
            mem_rd_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            ch_rdata_q <= '0;
            ch_ready_q <= '0;
            ch_done_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            wd_q       <= wd_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_be_q   <= mem_be_d;
            mem_rd_q   <= mem_rd_d;
            mem_we_q   <= mem_we_d;
            ch_rdata_q <= ch_rdata_d;
            ch_ready_q <= ch_ready_d;
            ch_done_q  <= ch_done_d;
            err_q      <= err_d;
        end
    end

    assign ch_rdata     = ch_rdata_q;
    assign ch_ready     = ch_ready_q;
    assign ch_done      = ch_done_q;
    assign err_timeout  = err_q;
    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign mem_we       = mem_we_q;
    assign mem_din      = mem_din_q;
    assign mem_be       = mem_be_q;
    assign mem_burstcnt = 8'd1;

endmodule

// File: tb/tb_ram_arbiter_nch.sv
// Directed bench for ram_arbiter_nch: a round-robin instance (TIMEOUT=16) and a
// fixed-priority instance sharing most stimulus.
module tb_ram_arbiter_nch;

    localparam int NCH    = 4;
    localparam int ADDR_W = 29;
    localparam int DATA_W = 64;
    localparam int BE_W   = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]         ch_req, ch_write, ch_req_b, ch_write_b;
    logic [NCH*ADDR_W-1:0]  ch_addr;
    logic [NCH*DATA_W-1:0]  ch_wdata;
    logic [NCH*BE_W-1:0]    ch_be;
    logic                   mem_busy, mem_dout_ready;
    logic [DATA_W-1:0]      mem_dout;

    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic [NCH-1:0]    ready_a, ready_b, done_a, done_b;
    logic              err_a, err_b, rd_a, rd_b, we_a, we_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] din_a, din_b;
    logic [BE_W-1:0]   be_a, be_b;
    logic [7:0]        burst_a, burst_b;

    int assert_count = 0;
    int fail_count   = 0;

    ram_arbiter_nch #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE(1), .TIMEOUT(16)) dut_rr (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_write(ch_write),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
        .ch_rdata(rdata_a), .ch_ready(ready_a), .ch_done(done_a), .err_timeout(err_a),
        .mem_busy(mem_busy), .mem_addr(addr_a), .mem_rd(rd_a), .mem_we(we_a),
        .mem_din(din_a), .mem_be(be_a), .mem_burstcnt(burst_a),
        .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready)
    );

    ram_arbiter_nch #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MODE(0), .TIMEOUT(1024)) dut_fp (
        .clk(clk), .reset_n(reset_n), .ch_req(ch_req_b), .ch_write(ch_write_b),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_be(ch_be),
        .ch_rdata(rdata_b), .ch_ready(ready_b), .ch_done(done_b), .err_timeout(err_b),
        .mem_busy(mem_busy), .mem_addr(addr_b), .mem_rd(rd_b), .mem_we(we_b),
        .mem_din(din_b), .mem_be(be_b), .mem_burstcnt(burst_b),
        .mem_dout(mem_dout), .mem_dout_ready(mem_dout_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic rd, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                                 input logic [BE_W-1:0] be);
        ch_req[ch]                    = rd;
        ch_write[ch]                  = wr;
        ch_addr[ch*ADDR_W +: ADDR_W]  = addr;
        ch_wdata[ch*DATA_W +: DATA_W] = wdata;
        ch_be[ch*BE_W +: BE_W]        = be;
    endtask

    // Read on the round-robin instance; data_at = cycles after acceptance that
    // mem_dout_ready is sampled (0 = never).
    task automatic runRead(input int ch, input logic [ADDR_W-1:0] addr, input int data_at,
                           input logic [63:0] data, input int exp_k, input logic exp_err,
                           input logic [63:0] exp_data, input string tag);
        int k;
        bit got;
        @(negedge clk);
        applyStimulus(ch, 1'b1, 1'b0, addr, '0, '0);
        mem_busy = 1'b0;
        @(negedge clk);
        checkOutput({tag, " mem_rd"}, 64'(rd_a), 64'd1);
        checkOutput({tag, " mem_addr"}, 64'(addr_a), 64'(addr));
        checkOutput({tag, " mem_be"}, 64'(be_a), 64'hFF);
        @(negedge clk);
        checkOutput({tag, " mem_rd drop"}, 64'(rd_a), 64'd0);
        k = 0;
        got = 1'b0;
        while (k < 40 && !got) begin
            if (k == data_at - 1) begin
                mem_dout_ready = 1'b1;
                mem_dout       = data;
            end
            @(negedge clk);
            k++;
            mem_dout_ready = 1'b0;
            if (ready_a != '0) got = 1'b1;
        end
        checkOutput({tag, " latency"}, 64'(k), 64'(exp_k));
        checkOutput({tag, " ch_ready"}, 64'(ready_a), 64'd1 << ch);
        checkOutput({tag, " err_timeout"}, 64'(err_a), 64'(exp_err));
        checkOutput({tag, " ch_rdata"}, rdata_a, exp_data);
        applyStimulus(ch, 1'b0, 1'b0, addr, '0, '0);
        @(negedge clk);
        checkOutput({tag, " ready pulse"}, 64'(ready_a), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int rd_cycles;
        logic [NCH-1:0] seen;
        logic [NCH-1:0] reass_a, reass_b;
        int order_a[$];
        int order_b[$];

        ch_req = '0; ch_write = '0; ch_req_b = '0; ch_write_b = '0;
        ch_addr = '0; ch_wdata = '0; ch_be = '0;
        mem_busy = 1'b0; mem_dout_ready = 1'b0; mem_dout = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset mem_rd", 64'(rd_a), 64'd0);
        checkOutput("reset mem_we", 64'(we_a), 64'd0);
        checkOutput("reset ch_ready", 64'(ready_a), 64'd0);
        checkOutput("reset ch_done", 64'(done_a), 64'd0);
        checkOutput("reset err", 64'(err_a), 64'd0);
        checkOutput("reset rdata", rdata_a, 64'd0);
        checkOutput("reset burstcnt", 64'(burst_a), 64'd1);
        reset_n = 1'b1;

        // Single write on channel 1
        @(negedge clk);
        applyStimulus(1, 1'b0, 1'b1, 29'h10, 64'h1111, 8'h0F);
        @(negedge clk);
        checkOutput("wr mem_we", 64'(we_a), 64'd1);
        checkOutput("wr mem_rd", 64'(rd_a), 64'd0);
        checkOutput("wr mem_addr", 64'(addr_a), 64'h10);
        checkOutput("wr mem_din", din_a, 64'h1111);
        checkOutput("wr mem_be", 64'(be_a), 64'h0F);
        checkOutput("wr done early", 64'(done_a), 64'd0);
        @(negedge clk);
        checkOutput("wr mem_we drop", 64'(we_a), 64'd0);
        checkOutput("wr ch_done", 64'(done_a), 64'h2);
        applyStimulus(1, 1'b0, 1'b0, 29'h10, 64'h1111, 8'h0F);
        @(negedge clk);
        checkOutput("wr done pulse", 64'(done_a), 64'd0);
        checkOutput("wr mem_rd never", 64'(rd_a), 64'd0);
        @(negedge clk);

        // Read with three cycles of backpressure
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 29'h20, '0, '0);
        mem_busy = 1'b1;
        rd_cycles = 0;
        seen = '0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (rd_a) rd_cycles++;
            seen |= ready_a;
            if (i == 3) mem_busy = 1'b0;
        end
        checkOutput("bp mem_rd cycles", 64'(rd_cycles), 64'd4);
        checkOutput("bp early ready", 64'(seen), 64'd0);
        mem_dout_ready = 1'b1;
        mem_dout = 64'hDEAD;
        @(negedge clk);
        mem_dout_ready = 1'b0;
        checkOutput("bp ch_ready", 64'(ready_a), 64'h1);
        checkOutput("bp ch_rdata", rdata_a, 64'hDEAD);
        checkOutput("bp err", 64'(err_a), 64'd0);
        applyStimulus(0, 1'b0, 1'b0, 29'h20, '0, '0);
        @(negedge clk);
        checkOutput("bp ready pulse", 64'(ready_a), 64'd0);
        @(negedge clk);

        // Both request and write on channel 2: write wins
        @(negedge clk);
        applyStimulus(2, 1'b1, 1'b1, 29'h60, 64'h2222, 8'hF0);
        @(negedge clk);
        checkOutput("rw mem_we", 64'(we_a), 64'd1);
        checkOutput("rw mem_rd", 64'(rd_a), 64'd0);
        checkOutput("rw mem_be", 64'(be_a), 64'hF0);
        @(negedge clk);
        checkOutput("rw ch_done", 64'(done_a), 64'h4);
        checkOutput("rw ch_ready", 64'(ready_a), 64'd0);
        applyStimulus(2, 1'b0, 1'b0, 29'h60, 64'h2222, 8'hF0);
        repeat (2) @(negedge clk);

        // Watchdog expiry, data just before expiry, and data coinciding with expiry
        runRead(3, 29'h40, 0, 64'h0, 16, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "timeout");
        runRead(3, 29'h44, 15, 64'h1234, 15, 1'b0, 64'h1234, "data15");
        runRead(2, 29'h48, 16, 64'h5678, 16, 1'b0, 64'h5678, "coincide");

        // Asynchronous reset during a pending write
        @(negedge clk);
        applyStimulus(0, 1'b0, 1'b1, 29'h70, 64'hABCD, 8'hFF);
        mem_busy = 1'b1;
        @(negedge clk);
        checkOutput("mid mem_we before", 64'(we_a), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mid mem_we", 64'(we_a), 64'd0);
        checkOutput("mid mem_addr", 64'(addr_a), 64'd0);
        checkOutput("mid mem_din", din_a, 64'd0);
        checkOutput("mid mem_be", 64'(be_a), 64'd0);
        checkOutput("mid burstcnt", 64'(burst_a), 64'd1);
        applyStimulus(0, 1'b0, 1'b0, 29'h70, 64'hABCD, 8'hFF);
        mem_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("mid idle we", 64'(we_a), 64'd0);

        // Reset while waiting for read data, then a stale mem_dout_ready
        @(negedge clk);
        applyStimulus(1, 1'b1, 1'b0, 29'h50, '0, '0);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstwait ready", 64'(ready_a), 64'd0);
        checkOutput("rstwait mem_rd", 64'(rd_a), 64'd0);
        applyStimulus(1, 1'b0, 1'b0, 29'h50, '0, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        mem_dout_ready = 1'b1;
        mem_dout = 64'hBEEF;
        @(negedge clk);
        mem_dout_ready = 1'b0;
        seen = ready_a;
        repeat (3) begin
            @(negedge clk);
            seen |= ready_a;
        end
        checkOutput("rstwait late ready", 64'(seen), 64'd0);
        checkOutput("rstwait err", 64'(err_a), 64'd0);
        runRead(1, 29'h30, 2, 64'hCAFE, 2, 1'b0, 64'hCAFE, "post-reset");

        // Continuous writes on all channels, both arbitration modes
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ch_write = 4'hF;
        ch_write_b = 4'hF;
        reass_a = '0;
        reass_b = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ch_write   |= reass_a;
            ch_write_b |= reass_b;
            reass_a = '0;
            reass_b = '0;
            for (int i = 0; i < NCH; i++) begin
                if (done_a[i]) begin
                    order_a.push_back(i);
                    ch_write[i] = 1'b0;
                    reass_a[i]  = 1'b1;
                end
                if (done_b[i]) begin
                    order_b.push_back(i);
                    ch_write_b[i] = 1'b0;
                    reass_b[i]    = 1'b1;
                end
            end
        end
        ch_write = '0;
        ch_write_b = '0;
        repeat (8) @(negedge clk);
        checkOutput("rr done count", 64'(order_a.size() >= 5), 64'd1);
        checkOutput("fp done count", 64'(order_b.size() >= 5), 64'd1);
        for (int j = 0; j < 5; j++) begin
            checkOutput($sformatf("rr order[%0d]", j),
                        64'((j < order_a.size()) ? order_a[j] : 99), 64'(j % 4));
            checkOutput($sformatf("fp order[%0d]", j),
                        64'((j < order_b.size()) ? order_b[j] : 99), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
